alu_execute_e: RTL and testbench
================================

// Module: alu_execute_e
// PURPOSE
//  Execute-stage consumer of the AluOp control word produced in decode.
//  Registers the decoded op and operands, decodes AluOp per instruction type,
//  and produces a registered result plus branch-compare flags.
//  Sits between the ID/EX boundary and the EX/MEM register.
//  Shifts are area-reduced: a 1-bit/cycle serial shifter back-pressures decode via oReady.
// PARAMETERS
//  DATA_WIDTH   32                   operand/result width
//  SHAMT_WIDTH  $clog2(DATA_WIDTH)   shift-amount width (5)
// PORTS
//  iClk              in   1           clock; all state on rising edge
//  iRstN             in   1           async active-low reset
//  iValid            in   1           decode presents an op this cycle
//  oReady            out  1           block can accept an op (accept = iValid & oReady)
//  iFlush            in   1           kill in-flight/incoming op (branch mispredict)
//  iInstructionType  in   InstructionTypes  selects the AluOp union view
//  iAluCtrl          in   AluOp       4-bit packed union from decode
//  iOperandA         in   DATA_WIDTH  rs1 / PC
//  iOperandB         in   DATA_WIDTH  rs2 / immediate
//  oValid            out  1           one-cycle pulse: oResult and flags valid
//  oResult           out  DATA_WIDTH  ALU result
//  oZero             out  1           A == B (BRANCH: SUB result == 0)
//  oLessSigned       out  1           $signed(A) < $signed(B)
//  oLessUnsigned     out  1           A < B unsigned
// BEHAVIOUR
//  Reset (async, iRstN=0): state IDLE; oValid, oResult, oZero, oLessSigned, oLessUnsigned = 0;
//   counters cleared; oReady = 1 immediately (combinational from IDLE).
//  Decode: REG_COMPUTATION view for REG_COMMPUTATION and BRANCH types;
//   IMM_COMPUTATION view for IMM_COMPUTATION, LOAD, STORE;
//   NULL (4'b1111) for JUMP, UPPER, other -> oResult = iOperandB (pass-through).
//  Arithmetic: ADD/SUB wrap modulo 2^DATA_WIDTH, no overflow flag; SLT/SLTU -> {31'b0, bit};
//   shamt = iOperandB[SHAMT_WIDTH-1:0], upper bits ignored. SRA sign-fills from bit 31.
//  Flags: computed every accepted op from the registered operands, valid with oValid.
//  FSM states: IDLE, SHIFT.
//   IDLE: oReady=1. On accept of non-shift op -> result registered, oValid=1 next cycle
//    (latency 1). On accept of shift with shamt=0 -> same as non-shift (latency 1).
//    On accept of shift with shamt>0 -> load shifter, count=shamt, go SHIFT.
//   SHIFT: oReady=0; shift 1 bit/cycle, count--; when count reaches 0 register result,
//    oValid=1 next cycle, return IDLE. Total latency = shamt+1 cycles after accept.
//  Back-to-back: a non-shift op may be accepted every cycle; oValid may stay high for consecutive cycles.
//  iValid while oReady=0: ignored; decode must hold it (not captured).
//  iFlush: highest priority. In IDLE, any same-cycle input is dropped.
//   In SHIFT, abort to IDLE. oValid=0 on the following cycle in every case.
//   oResult/flags may hold stale data (qualified by oValid only).
//  Flush and completion in the same cycle: flush wins, no oValid.
//  Reset mid-shift: immediate return to IDLE, all outputs 0.
//  Unknown AluOp encoding in a valid view: oResult = 0, oValid still pulses.
// STRUCTURE
//  Shared package (ControlTypeDefs): AluExecState enum {IDLE, SHIFT};
//   function automatic logic IsShiftOp(InstructionTypes, AluOp) covering SLL/SRL/SRA and IMM forms;
//   localparam ALU_NULL = 4'b1111.
//  Sub-module: alu_serial_shifter
//   (load, dir, arith, count; done pulse; DATA_WIDTH-parametrised).
//  Top: FSM, decode mux, combinational ALU core, output registers.
// TESTING
//  1. Reset asserted mid-SHIFT (SLL, B=20, 5 cycles in) -> outputs 0, oReady=1
//     while iRstN=0; next op accepted normally.
//  2. REG ADD A=32'hFFFF_FFFF, B=1 -> 1 cycle later oValid=1, oResult=0, oZero=0
//     (wrap, no overflow).
//  3. BRANCH SUB A=5, B=5 -> oZero=1, oLessSigned=0; A=-1, B=1 -> oLessSigned=1,
//     oLessUnsigned=0.
//  4. IMM SRA A=32'h8000_0000, B=4 -> oReady=0 for 4 cycles, oValid at +5,
//     oResult=32'hF800_0000.
//  5. SLL B=0 then ADD next cycle -> both accepted back-to-back, oValid high
//     2 consecutive cycles.
//  6. SRL B=31 with iFlush at cycle 10 -> no oValid, oReady=1 next cycle.
//     Flush with iValid in IDLE -> op dropped.

Source files
------------

// File: rtl/alu_execute_e_pkg.sv
// Shared execute-stage types: instruction classes, the AluOp decode union and the
// resolved internal op used by the datapath.
package alu_execute_e_pkg;

  localparam logic [3:0] ALU_NULL = 4'b1111;

  typedef enum logic [2:0] {
    REG_COMMPUTATION = 3'd0,
    IMM_COMPUTATION  = 3'd1,
    LOAD             = 3'd2,
    STORE            = 3'd3,
    BRANCH           = 3'd4,
    JUMP             = 3'd5,
    UPPER            = 3'd6
  } InstructionTypes;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_OR   = 4'd8, ALU_AND = 4'd9, ALU_NULL_R = 4'hF
  } RegAluOp;

  typedef enum logic [3:0] {
    ALU_ADDI = 4'd0, ALU_SLTI = 4'd1, ALU_SLTIU = 4'd2, ALU_XORI = 4'd3,
    ALU_ORI  = 4'd4, ALU_ANDI = 4'd5, ALU_SLLI  = 4'd6, ALU_SRLI = 4'd7,
    ALU_SRAI = 4'd8, ALU_NULL_I = 4'hF
  } ImmAluOp;

  typedef union packed {
    RegAluOp reg_op;
    ImmAluOp imm_op;
  } AluOp;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} AluExecState;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND, OP_PASS, OP_BAD
  } ExecOp;

  // Collapses the per-type union view into one op; NULL encoding passes B through.
  function automatic ExecOp DecodeOp(InstructionTypes itype, AluOp ctrl);
    ExecOp op;
    op = OP_BAD;
    if (ctrl == ALU_NULL) begin
      op = OP_PASS;
    end else begin
      case (itype)
        REG_COMMPUTATION, BRANCH: begin
          case (ctrl.reg_op)
            ALU_ADD:  op = OP_ADD;
            ALU_SUB:  op = OP_SUB;
            ALU_SLL:  op = OP_SLL;
            ALU_SLT:  op = OP_SLT;
            ALU_SLTU: op = OP_SLTU;
            ALU_XOR:  op = OP_XOR;
            ALU_SRL:  op = OP_SRL;
            ALU_SRA:  op = OP_SRA;
            ALU_OR:   op = OP_OR;
            ALU_AND:  op = OP_AND;
            default:  op = OP_BAD;
          endcase
        end
        IMM_COMPUTATION, LOAD, STORE: begin
          case (ctrl.imm_op)
            ALU_ADDI:  op = OP_ADD;
            ALU_SLTI:  op = OP_SLT;
            ALU_SLTIU: op = OP_SLTU;
            ALU_XORI:  op = OP_XOR;
            ALU_ORI:   op = OP_OR;
            ALU_ANDI:  op = OP_AND;
            ALU_SLLI:  op = OP_SLL;
            ALU_SRLI:  op = OP_SRL;
            ALU_SRAI:  op = OP_SRA;
            default:   op = OP_BAD;
          endcase
        end
        default: op = OP_PASS;
      endcase
    end
    return op;
  endfunction

  function automatic logic IsShiftOp(InstructionTypes itype, AluOp ctrl);
    ExecOp op;
    op = DecodeOp(itype, ctrl);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_execute_e_if.sv
// ID/EX handshake bundle: decode drives the op (master), execute consumes it and
// returns the registered result and compare flags (slave).
interface alu_execute_e_if
  import alu_execute_e_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) ();

  logic                  iValid;
  logic                  oReady;
  logic                  iFlush;
  InstructionTypes       iInstructionType;
  AluOp                  iAluCtrl;
  logic [DATA_WIDTH-1:0] iOperandA;
  logic [DATA_WIDTH-1:0] iOperandB;
  logic                  oValid;
  logic [DATA_WIDTH-1:0] oResult;
  logic                  oZero;
  logic                  oLessSigned;
  logic                  oLessUnsigned;

  modport master (
    output iValid, iFlush, iInstructionType, iAluCtrl, iOperandA, iOperandB,
    input  oReady, oValid, oResult, oZero, oLessSigned, oLessUnsigned
  );

  modport slave (
    input  iValid, iFlush, iInstructionType, iAluCtrl, iOperandA, iOperandB,
    output oReady, oValid, oResult, oZero, oLessSigned, oLessUnsigned
  );

endinterface

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter: load captures data/amount, then shifts each cycle while count != 0.
// done is high in the cycle whose shift is the last one; data_out is that shift's value.
module alu_serial_shifter #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   clear,
  input  logic                   dir_right,
  input  logic                   arith,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic [SHAMT_WIDTH-1:0] count_in,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  data_out
);

  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [SHAMT_WIDTH-1:0] count_q, count_d;
  logic                   dir_q, dir_d;
  logic                   arith_q, arith_d;

  assign data_out = dir_q ? {arith_q & data_q[DATA_WIDTH-1], data_q[DATA_WIDTH-1:1]}
                          : {data_q[DATA_WIDTH-2:0], 1'b0};
  assign done     = (count_q == SHAMT_WIDTH'(1));

  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    dir_d   = dir_q;
    arith_d = arith_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      data_d  = data_in;
      count_d = count_in;
      dir_d   = dir_right;
      arith_d = arith;
    end else if (count_q != '0) begin
      data_d  = data_out;
      count_d = count_q - SHAMT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
    end
  end

endmodule

// File: rtl/alu_execute_e.sv
// Execute-stage ALU: latency 1 for non-shifts and zero-amount shifts, shamt+1 for serial shifts.
// oReady drops for the whole serial shift; iValid is ignored (not captured) while oReady is low.
module alu_execute_e
  import alu_execute_e_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic          iClk,
  input  logic          iRstN,
  alu_execute_e_if.slave bus
);

  AluExecState           state_q, state_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic                  lt_s_q, lt_s_d;
  logic                  lt_u_q, lt_u_d;

  ExecOp                  op;
  logic [DATA_WIDTH-1:0]  opa, opb;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   accept, start_shift;
  logic                   lt_s, lt_u;
  logic                   shift_done;
  logic [DATA_WIDTH-1:0]  alu_res, shift_res;

  assign opa         = bus.iOperandA;
  assign opb         = bus.iOperandB;
  assign op          = DecodeOp(bus.iInstructionType, bus.iAluCtrl);
  assign shamt       = opb[SHAMT_WIDTH-1:0];
  assign accept      = bus.iValid && (state_q == IDLE) && !bus.iFlush;
  assign start_shift = accept && IsShiftOp(bus.iInstructionType, bus.iAluCtrl) && (shamt != '0);
  assign lt_s        = $signed(opa) < $signed(opb);
  assign lt_u        = opa < opb;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = opa + opb;
      OP_SUB:  alu_res = opa - opb;
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, lt_u};
      OP_XOR:  alu_res = opa ^ opb;
      OP_OR:   alu_res = opa | opb;
      OP_AND:  alu_res = opa & opb;
      // Only zero-amount shifts take this path; the rest go through the serial unit.
      OP_SLL, OP_SRL, OP_SRA: alu_res = opa;
      OP_PASS: alu_res = opb;
      default: alu_res = '0;
    endcase
  end

  alu_serial_shifter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_shifter (
    .clk       (iClk),
    .rst_n     (iRstN),
    .load      (start_shift),
    .clear     (bus.iFlush),
    .dir_right (op != OP_SLL),
    .arith     (op == OP_SRA),
    .data_in   (opa),
    .count_in  (shamt),
    .done      (shift_done),
    .data_out  (shift_res)
  );

  always_comb begin
    state_d  = state_q;
    valid_d  = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    lt_s_d   = lt_s_q;
    lt_u_d   = lt_u_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          zero_d = (opa == opb);
          lt_s_d = lt_s;
          lt_u_d = lt_u;
          if (start_shift) begin
            state_d = SHIFT;
          end else begin
            result_d = alu_res;
            valid_d  = 1'b1;
          end
        end
      end
      SHIFT: begin
        // Flush beats a completion landing in the same cycle.
        if (bus.iFlush) begin
          state_d = IDLE;
        end else if (shift_done) begin
          result_d = shift_res;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      lt_s_q   <= 1'b0;
      lt_u_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      lt_s_q   <= lt_s_d;
      lt_u_q   <= lt_u_d;
    end
  end

  assign bus.oReady        = (state_q == IDLE);
  assign bus.oValid        = valid_q;
  assign bus.oResult       = result_q;
  assign bus.oZero         = zero_q;
  assign bus.oLessSigned   = lt_s_q;
  assign bus.oLessUnsigned = lt_u_q;

endmodule

// File: tb/tb_alu_execute_e.sv
// Scoreboard bench for alu_execute_e: expected results queued at drive time, popped on oValid.
module tb_alu_execute_e;
  import alu_execute_e_pkg::*;

  logic iClk = 1'b0;
  logic iRstN;
  always #5 iClk = ~iClk;

  alu_execute_e_if #(.DATA_WIDTH(32)) bus ();

  alu_execute_e #(.DATA_WIDTH(32)) dut (
    .iClk  (iClk),
    .iRstN (iRstN),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ls;
    logic        lu;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_miss = 0;

  always @(posedge iClk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_res(input InstructionTypes t, input logic [3:0] c,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    if (c == 4'hF || t == JUMP || t == UPPER) return b;
    if (t == REG_COMMPUTATION || t == BRANCH) begin
      case (c)
        4'd0: return a + b;
        4'd1: return a - b;
        4'd2: return a << sh;
        4'd3: return {31'd0, $signed(a) < $signed(b)};
        4'd4: return {31'd0, a < b};
        4'd5: return a ^ b;
        4'd6: return a >> sh;
        4'd7: return $signed(a) >>> sh;
        4'd8: return a | b;
        4'd9: return a & b;
        default: return 32'd0;
      endcase
    end
    case (c)
      4'd0: return a + b;
      4'd1: return {31'd0, $signed(a) < $signed(b)};
      4'd2: return {31'd0, a < b};
      4'd3: return a ^ b;
      4'd4: return a | b;
      4'd5: return a & b;
      4'd6: return a << sh;
      4'd7: return a >> sh;
      4'd8: return $signed(a) >>> sh;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int shift_lat(input InstructionTypes t, input logic [3:0] c, input logic [31:0] b);
    bit is_sh;
    is_sh = 1'b0;
    if (t == REG_COMMPUTATION || t == BRANCH) is_sh = (c == 4'd2) || (c == 4'd6) || (c == 4'd7);
    else if (t == IMM_COMPUTATION || t == LOAD || t == STORE) is_sh = (c == 4'd6) || (c == 4'd7) || (c == 4'd8);
    return is_sh ? int'(b[4:0]) : 0;
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue(input InstructionTypes t, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b, input bit push);
    int   n;
    exp_t e;
    n = 0;
    while (bus.oReady !== 1'b1 && n < 64) begin
      @(negedge iClk);
      n++;
    end
    if (n >= 64) chk("rdy_timeout", 64'd0, 64'd1);
    bus.iValid           = 1'b1;
    bus.iInstructionType = t;
    bus.iAluCtrl         = c;
    bus.iOperandA        = a;
    bus.iOperandB        = b;
    if (push) begin
      e.res = model_res(t, c, a, b);
      e.z   = (a == b);
      e.ls  = $signed(a) < $signed(b);
      e.lu  = a < b;
      e.cyc = cyc + 1 + shift_lat(t, c, b);
      sbq.push_back(e);
    end
    @(negedge iClk);
    bus.iValid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vld"}, bus.oValid, 0);
    chk({tag, "_res"}, bus.oResult, 0);
    chk({tag, "_zero"}, bus.oZero, 0);
    chk({tag, "_lts"}, bus.oLessSigned, 0);
    chk({tag, "_ltu"}, bus.oLessUnsigned, 0);
    chk({tag, "_rdy"}, bus.oReady, 1);
  endtask

  always @(negedge iClk) begin
    if (iRstN && bus.oValid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("spurious_vld", 64'd1, 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("res", bus.oResult, mon_e.res);
        chk("zero", bus.oZero, mon_e.z);
        chk("lts", bus.oLessSigned, mon_e.ls);
        chk("ltu", bus.oLessUnsigned, mon_e.lu);
        chk("lat_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int          n;
    logic [31:0] ra, rb;
    bus.iValid           = 1'b0;
    bus.iFlush           = 1'b0;
    bus.iInstructionType = REG_COMMPUTATION;
    bus.iAluCtrl         = 4'h0;
    bus.iOperandA        = '0;
    bus.iOperandB        = '0;
    iRstN                = 1'b0;
    repeat (2) @(negedge iClk);
    chk_idle("rst");
    iRstN = 1'b1;
    @(negedge iClk);

    // Wrap-around add, branch compares, logic ops and decode corners
    issue(REG_COMMPUTATION, 4'd0, 32'hFFFF_FFFF, 32'd1, 1);
    issue(BRANCH, 4'd1, 32'd5, 32'd5, 1);
    issue(BRANCH, 4'd1, 32'hFFFF_FFFF, 32'd1, 1);
    issue(REG_COMMPUTATION, 4'd4, 32'd3, 32'h8000_0000, 1);
    issue(REG_COMMPUTATION, 4'd3, 32'd3, 32'h8000_0000, 1);
    issue(REG_COMMPUTATION, 4'd5, 32'hF0F0_1234, 32'h0FF0_4321, 1);
    issue(IMM_COMPUTATION, 4'd4, 32'hA000_0005, 32'h0000_0F00, 1);
    issue(LOAD, 4'd0, 32'h1000_0000, 32'h0000_0010, 1);
    issue(STORE, 4'd5, 32'hDEAD_BEEF, 32'h0000_FFFF, 1);
    issue(JUMP, 4'd0, 32'h1111_1111, 32'h2222_2222, 1);
    issue(UPPER, 4'd3, 32'h0, 32'hABCD_E000, 1);
    issue(REG_COMMPUTATION, ALU_NULL, 32'h5, 32'h77, 1);
    issue(REG_COMMPUTATION, 4'hC, 32'h5, 32'h6, 1);
    issue(IMM_COMPUTATION, 4'hE, 32'h5, 32'h6, 1);

    // Serial arithmetic right shift holds off decode for shamt cycles
    issue(IMM_COMPUTATION, 4'd8, 32'h8000_0000, 32'd4, 1);
    for (int i = 0; i < 4; i++) begin
      chk("sra_busy", bus.oReady, 0);
      @(negedge iClk);
    end
    chk("sra_ready", bus.oReady, 1);

    // Zero-amount shift (upper shamt bits ignored) then ADD back-to-back
    issue(REG_COMMPUTATION, 4'd2, 32'h0000_1234, 32'h0000_0020, 1);
    issue(REG_COMMPUTATION, 4'd0, 32'd40, 32'd2, 1);
    issue(REG_COMMPUTATION, 4'd6, 32'hF000_0000, 32'd3, 1);
    issue(BRANCH, 4'd1, 32'd9, 32'd4, 1);

    // Reset five cycles into a long shift
    issue(REG_COMMPUTATION, 4'd2, 32'h1, 32'd20, 1);
    repeat (4) @(negedge iClk);
    iRstN = 1'b0;
    sbq.delete();
    #1;
    chk_idle("rst_mid");
    @(negedge iClk);
    iRstN = 1'b1;
    @(negedge iClk);
    issue(REG_COMMPUTATION, 4'd0, 32'd7, 32'd8, 1);

    // Flush at cycle 10 of a 31-cycle shift
    issue(REG_COMMPUTATION, 4'd6, 32'hFFFF_FFFF, 32'd31, 0);
    repeat (9) @(negedge iClk);
    bus.iFlush = 1'b1;
    @(negedge iClk);
    bus.iFlush = 1'b0;
    chk("flush_shift_rdy", bus.oReady, 1);
    chk("flush_shift_vld", bus.oValid, 0);
    repeat (30) @(negedge iClk);

    // Flush coincides with the final shift cycle
    issue(REG_COMMPUTATION, 4'd2, 32'h1, 32'd3, 0);
    repeat (2) @(negedge iClk);
    bus.iFlush = 1'b1;
    @(negedge iClk);
    bus.iFlush = 1'b0;
    chk("flush_done_vld", bus.oValid, 0);
    chk("flush_done_rdy", bus.oReady, 1);

    // Flush alongside a valid op in IDLE drops it
    bus.iValid           = 1'b1;
    bus.iFlush           = 1'b1;
    bus.iInstructionType = REG_COMMPUTATION;
    bus.iAluCtrl         = 4'd0;
    bus.iOperandA        = 32'd100;
    bus.iOperandB        = 32'd200;
    @(negedge iClk);
    bus.iValid = 1'b0;
    bus.iFlush = 1'b0;
    chk("flush_idle_vld", bus.oValid, 0);
    repeat (2) @(negedge iClk);
    issue(REG_COMMPUTATION, 4'd1, 32'd1, 32'd2, 1);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      issue(InstructionTypes'(3'($urandom_range(0, 6))), 4'($urandom_range(0, 15)), ra, rb, 1);
    end

    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge iClk);
      n++;
    end
    chk("sb_drain", sbq.size(), 0);
    repeat (3) @(negedge iClk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
